m26_fifo_arbiter: RTL and testbench

M26_FIFO_ARBITER -- requirements
Module: m26_fifo_arbiter

---
 rtl/m26_arb_pkg.sv | 24 ++
 rtl/m26_fifo_arbiter_rr_pick.sv | 33 +++
 rtl/m26_fifo_arbiter.sv | 129 ++++++++++++
 tb/tb_m26_fifo_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m26_arb_pkg.sv
// m26_arb_pkg: shared types and helpers for the m26 FIFO arbiter.
// Holds the FSM encoding and the round-robin index step.
package m26_arb_pkg;

   localparam int IDX_W  = 3;
   localparam int MAX_CH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Next channel index after idx, wrapping at n.
   function automatic logic [IDX_W-1:0] rr_next(
      input logic [IDX_W-1:0] idx,
      input int unsigned      n
   );
      logic [31:0] wide;
      wide = {{(32-IDX_W){1'b0}}, idx} + 32'd1;
      if (wide >= n) return '0;
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/m26_fifo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans from last+1 upward, wrapping, and returns the first request.
module rr_pick
   import m26_arb_pkg::*;
#(
   parameter int N_CH = 6
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [MAX_CH-1:0] req_x;
   logic [IDX_W-1:0]  cand;

   // Walk N_CH candidates after last; first hit wins.
   always_comb begin
      req_x             = '0;
      req_x[N_CH-1:0]   = req;
      found             = 1'b0;
      idx               = '0;
      cand              = last;
      for (int k = 0; k < N_CH; k++) begin
         cand = rr_next(cand, N_CH);
         if (!found && req_x[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/m26_fifo_arbiter.sv
// m26_fifo_arbiter: round-robin merge of N_CH m26 receiver FIFOs
// into a single held 32-bit output word, with optional burst limit.
module m26_fifo_arbiter
   import m26_arb_pkg::*;
#(
   parameter int N_CH  = 6,
   parameter int CNT_W = 8
) (
   input  logic                BUS_CLK,
   input  logic                RST,
   input  logic [N_CH-1:0]     CH_EN,
   input  logic [CNT_W-1:0]    BURST_LEN,
   input  logic [N_CH-1:0]     CH_EMPTY,
   input  logic [32*N_CH-1:0]  CH_DATA,
   output logic [N_CH-1:0]     CH_READ,
   input  logic                OUT_READ,
   output logic                OUT_EMPTY,
   output logic [31:0]         OUT_DATA,
   output logic [2:0]          GRANT_ID,
   output logic [15:0]         SWITCH_CNT
);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              valid_q, valid_d;
   logic [31:0]       data_q, data_d;
   logic [15:0]       sw_q, sw_d;

   logic [MAX_CH-1:0] en_x, empty_x, rd_x;
   logic [N_CH-1:0]   req;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [31:0]       ch_word;
   logic              slot_free, load, done;

   // Widen per-channel vectors so grant_q can index them directly.
   always_comb begin
      en_x               = '0;
      en_x[N_CH-1:0]     = CH_EN;
      empty_x            = '1;
      empty_x[N_CH-1:0]  = CH_EMPTY;
      req                = CH_EN & ~CH_EMPTY;
      ch_word            = CH_DATA[{grant_q, 5'd0} +: 32];
   end

   rr_pick #(
      .N_CH (N_CH)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant FSM, burst counting and output word register update.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      data_d    = data_q;
      sw_d      = sw_q;
      rd_x      = '0;
      load      = 1'b0;
      done      = 1'b0;
      cnt_inc   = cnt_q;
      slot_free = !valid_q || OUT_READ;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            load = !RST && slot_free && en_x[grant_q]
                   && !empty_x[grant_q];
            if (load && cnt_q != '1) cnt_inc = cnt_q + CNT_W'(1);
            done = empty_x[grant_q] || !en_x[grant_q]
                   || (BURST_LEN != '0 && cnt_inc >= BURST_LEN);
            if (load) begin
               rd_x[grant_q] = 1'b1;
               data_d        = ch_word;
               cnt_d         = cnt_inc;
            end
            if (done) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
               if (sw_q != '1) sw_d = sw_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load)          valid_d = 1'b1;
      else if (OUT_READ) valid_d = 1'b0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_CH - 1);
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         sw_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sw_q    <= sw_d;
      end
   end

   assign CH_READ    = rd_x[N_CH-1:0];
   assign OUT_EMPTY  = !valid_q;
   assign OUT_DATA   = data_q;
   assign GRANT_ID   = grant_q;
   assign SWITCH_CNT = sw_q;

endmodule

// File: tb/tb_m26_fifo_arbiter.sv
// tb_m26_fifo_arbiter: scoreboard bench for the m26 FIFO arbiter.
// Source FIFOs are modelled as queues; a monitor checks the output.
module tb_m26_fifo_arbiter;

   localparam int N  = 6;
   localparam int CW = 8;

   logic              BUS_CLK = 1'b0;
   logic              RST;
   logic [N-1:0]      CH_EN, CH_EMPTY, CH_READ;
   logic [CW-1:0]     BURST_LEN;
   logic [32*N-1:0]   CH_DATA;
   logic              OUT_READ, OUT_EMPTY;
   logic [31:0]       OUT_DATA;
   logic [2:0]        GRANT_ID;
   logic [15:0]       SWITCH_CNT;

   m26_fifo_arbiter #(
      .N_CH  (N),
      .CNT_W (CW)
   ) dut (
      .BUS_CLK    (BUS_CLK),
      .RST        (RST),
      .CH_EN      (CH_EN),
      .BURST_LEN  (BURST_LEN),
      .CH_EMPTY   (CH_EMPTY),
      .CH_DATA    (CH_DATA),
      .CH_READ    (CH_READ),
      .OUT_READ   (OUT_READ),
      .OUT_EMPTY  (OUT_EMPTY),
      .OUT_DATA   (OUT_DATA),
      .GRANT_ID   (GRANT_ID),
      .SWITCH_CNT (SWITCH_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   logic [31:0]   src [N][$];
   logic [31:0]   exp_q [$];
   int            out_ch [$];
   int            seq_nxt [N];
   int            last_seq [N];
   logic [N-1:0]  en, emask, shown;
   logic          oread;
   logic [CW-1:0] blen;
   int            checks, passes, pushed, delivered, rd_pulses;
   logic [31:0]   mon_w;
   int            mon_c;

   task automatic chk(input bit ok, input string name,
                      input longint act, input longint req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h want %0h", name, act, req);
   endtask

   task automatic push_words(input int ch, input int n);
      repeat (n) begin
         src[ch].push_back({4'(ch), 4'($urandom), 24'(seq_nxt[ch])});
         seq_nxt[ch]++;
         pushed++;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         shown[i] = (src[i].size() == 0) || emask[i];
         CH_DATA[32*i +: 32] = (src[i].size() != 0) ? src[i][0]
                                                     : $urandom;
      end
      CH_EMPTY  = shown;
      CH_EN     = en;
      OUT_READ  = oread;
      BURST_LEN = blen;
   endtask

   // One clock: drive, sample pops at negedge, return after posedge.
   task automatic step();
      logic [N-1:0] cr;
      drive();
      @(negedge BUS_CLK);
      cr = CH_READ;
      if (RST) begin
         chk(cr == '0, "rst_read", cr, 0);
      end else if (cr != '0) begin
         rd_pulses++;
         chk($countones(cr) == 1, "onehot", $countones(cr), 1);
         chk((cr & (shown | ~en)) == '0, "illegal_read",
             cr, ~shown & en);
         for (int i = 0; i < N; i++)
            if (cr[i] && src[i].size() > 0)
               exp_q.push_back(src[i].pop_front());
      end
      @(posedge BUS_CLK);
      #1;
   endtask

   // Output monitor: every consumed word must be the next expected one.
   always @(negedge BUS_CLK) begin
      if (!RST && OUT_READ && !OUT_EMPTY) begin
         chk(exp_q.size() != 0, "unexpected_word", OUT_DATA, 0);
         if (exp_q.size() != 0) begin
            mon_w = exp_q.pop_front();
            chk(OUT_DATA == mon_w, "out_data", OUT_DATA, mon_w);
            mon_c = int'(OUT_DATA[31:28]);
            if (mon_c < N) begin
               chk(int'(OUT_DATA[23:0]) > last_seq[mon_c], "chan_order",
                   OUT_DATA[23:0], last_seq[mon_c] + 1);
               last_seq[mon_c] = int'(OUT_DATA[23:0]);
            end
            out_ch.push_back(mon_c);
            delivered++;
         end
      end
   end

   function automatic bit idle_now();
      for (int i = 0; i < N; i++)
         if (en[i] && src[i].size() > 0) return 1'b0;
      return exp_q.size() == 0 && OUT_EMPTY;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while (!idle_now() && n < budget) begin
         step();
         n++;
      end
      chk(n < budget, "drain_timeout", n, budget);
      repeat (4) step();
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1;
      repeat (n) step();
      RST = 1'b0;
      exp_q.delete();
      out_ch.delete();
   endtask

   task automatic new_test();
      for (int i = 0; i < N; i++) src[i].delete();
      en    = '1;
      emask = '0;
      oread = 1'b1;
      blen  = '0;
      do_reset(1);
   endtask

   function automatic int count_ch(input int c);
      int n = 0;
      foreach (out_ch[k]) if (out_ch[k] == c) n++;
      return n;
   endfunction

   function automatic int first_diff(input int a [$], input int b [$]);
      if (a.size() != b.size()) return -2;
      foreach (a[k]) if (a[k] != b[k]) return k;
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ord [$];
      int          rem [N];
      int          left, p, k, p0, d0, nw, first;
      bit          stable, seen;
      logic [31:0] hold, w0;

      checks = 0; passes = 0; pushed = 0; delivered = 0; rd_pulses = 0;
      for (int i = 0; i < N; i++) begin
         seq_nxt[i]  = 0;
         last_seq[i] = -1;
      end
      RST = 1'b1; en = '1; emask = '0; oread = 1'b1; blen = '0;
      drive();
      @(posedge BUS_CLK);
      #1;
      do_reset(2);

      // Reset values.
      chk(OUT_EMPTY == 1'b1, "rst_out_empty", OUT_EMPTY, 1);
      chk(OUT_DATA == 32'd0, "rst_out_data", OUT_DATA, 0);
      chk(CH_READ == '0, "rst_ch_read", CH_READ, 0);
      chk(GRANT_ID == 3'd0, "rst_grant", GRANT_ID, 0);
      chk(SWITCH_CNT == 16'd0, "rst_switch", SWITCH_CNT, 0);

      // Two channels, unlimited burst.
      new_test();
      push_words(0, 4);
      push_words(3, 4);
      drain(200);
      ord = '{0, 0, 0, 0, 3, 3, 3, 3};
      chk(first_diff(out_ch, ord) == -1, "two_ch_order",
          first_diff(out_ch, ord), -1);
      chk(SWITCH_CNT == 16'd2, "two_ch_switch", SWITCH_CNT, 2);

      // All channels, 10 words each, burst of 3.
      new_test();
      for (int i = 0; i < N; i++) push_words(i, 10);
      blen = CW'(3);
      drain(500);
      ord.delete();
      for (int i = 0; i < N; i++) rem[i] = 10;
      left = 10 * N;
      p = 0;
      while (left > 0) begin
         k = (rem[p] < 3) ? rem[p] : 3;
         repeat (k) ord.push_back(p);
         rem[p] -= k;
         left   -= k;
         p = (p + 1) % N;
      end
      chk(out_ch.size() == 60, "burst_total", out_ch.size(), 60);
      chk(first_diff(out_ch, ord) == -1, "burst_order",
          first_diff(out_ch, ord), -1);
      chk(SWITCH_CNT == 16'(4 * N), "burst_switch", SWITCH_CNT, 4 * N);

      // Downstream stalled for 20 cycles.
      new_test();
      oread = 1'b0;
      push_words(1, 6);
      w0 = src[1][0];
      p0 = rd_pulses;
      stable = 1'b1; seen = 1'b0; hold = '0;
      repeat (20) begin
         step();
         if (!OUT_EMPTY) begin
            if (!seen) begin
               hold = OUT_DATA;
               seen = 1'b1;
            end else if (OUT_DATA != hold) stable = 1'b0;
         end
      end
      chk(rd_pulses - p0 == 1, "stall_reads", rd_pulses - p0, 1);
      chk(seen && stable, "stall_stable", {seen, stable}, 3);
      chk(hold == w0, "stall_word", hold, w0);
      oread = 1'b1;
      drain(100);
      chk(count_ch(1) == 6, "stall_delivered", count_ch(1), 6);

      // Channel disabled mid-grant.
      new_test();
      push_words(2, 8);
      push_words(4, 3);
      nw = 0;
      while (src[2].size() > 5 && nw < 60) begin
         step();
         nw++;
      end
      chk(nw < 60, "dis_wait", nw, 60);
      en[2] = 1'b0;
      drain(200);
      chk(src[2].size() == 5, "dis_kept", src[2].size(), 5);
      chk(count_ch(2) == 3, "dis_ch2", count_ch(2), 3);
      chk(count_ch(4) == 3, "dis_ch4", count_ch(4), 3);

      // Reset in the middle of a burst.
      new_test();
      blen = CW'(2);
      push_words(2, 6);
      push_words(5, 6);
      nw = 0;
      while (src[5].size() > 5 && nw < 60) begin
         step();
         nw++;
      end
      chk(nw < 60, "mid_rst_wait", nw, 60);
      do_reset(1);
      chk(OUT_EMPTY == 1'b1, "mid_rst_empty", OUT_EMPTY, 1);
      chk(SWITCH_CNT == 16'd0, "mid_rst_switch", SWITCH_CNT, 0);
      left = src[2].size() + src[5].size();
      drain(200);
      first = (out_ch.size() != 0) ? out_ch[0] : -1;
      chk(first == 2, "mid_rst_first", first, 2);
      chk(out_ch.size() == left, "mid_rst_rest", out_ch.size(), left);

      // Random traffic, then drain everything.
      new_test();
      p0 = pushed;
      d0 = delivered;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, N - 1);
            if (src[k].size() < 16) push_words(k, 1);
         end
         emask = N'($urandom & $urandom);
         oread = ($urandom_range(0, 3) != 0);
         if (c % 250 == 0) begin
            en   = N'($urandom) | N'(1 << $urandom_range(0, N - 1));
            blen = CW'($urandom_range(0, 4));
         end
         step();
      end
      en    = '1;
      emask = '0;
      oread = 1'b1;
      drain(3000);
      chk(delivered - d0 == pushed - p0, "rand_conserve",
          delivered - d0, pushed - p0);
      chk(exp_q.size() == 0, "rand_leftover", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
